// File: rtl/chimera_cluster_seq.sv
// chimera_cluster_seq: round-robin power-up/power-down sequencer for the external compute clusters.
// Optional feature macro CHIMERA_CLUSTER_SEQ_WFI_GATE_EN: stops wait until the cluster reports idle.
module chimera_cluster_seq #(
   parameter int NumClusters     = 5,
   parameter int ClkSettleCycles = 8,
   parameter int RstHoldCycles   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumClusters-1:0] start_i,
   input  logic [NumClusters-1:0] stop_i,
`ifdef CHIMERA_CLUSTER_SEQ_WFI_GATE_EN
   input  logic [NumClusters-1:0] cluster_idle_i,
`endif
   output logic [NumClusters-1:0] clk_en_o,
   output logic [NumClusters-1:0] rst_o,
   output logic [NumClusters-1:0] boot_irq_o,
   output logic [NumClusters-1:0] on_o,
   output logic                   busy_o
);
   localparam int IW       = NumClusters > 1 ? $clog2(NumClusters) : 1;
   localparam int MaxDwell = ClkSettleCycles > RstHoldCycles ? ClkSettleCycles : RstHoldCycles;
   localparam int CW       = $clog2(MaxDwell + 1);

   typedef enum logic [2:0] {IDLE, UP_CLK, UP_RST, UP_IRQ, DN_RST, DN_CLK} state_t;

   state_t                 state;
   logic [NumClusters-1:0] pend_start, pend_stop, stop_ok, elig, gmask, clr_start, clr_stop;
   logic [IW-1:0]          ptr, grant, cur;
   logic [CW-1:0]          cnt;
   logic                   found;

   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v >= NumClusters ? v - NumClusters : v);
   endfunction

`ifdef CHIMERA_CLUSTER_SEQ_WFI_GATE_EN
   logic [NumClusters-1:0] idle_q;

   // sample the cluster idle flags so a stop is granted on the same latency as a request
   always_ff @(posedge clk_i) begin
      idle_q <= rst_i ? '0 : cluster_idle_i;
   end

   assign stop_ok = idle_q;
`else
   assign stop_ok = '1;
`endif

   assign elig   = (pend_start & ~on_o) | (pend_stop & on_o & stop_ok);
   assign busy_o = state != IDLE;

   // first eligible cluster at or after the pointer; scanning backwards leaves the nearest one
   always_comb begin
      grant = ptr;
      found = 1'b0;
      for (int i = NumClusters - 1; i >= 0; i--) begin
         if (elig[wrap(int'(ptr) + i)]) begin
            grant = wrap(int'(ptr) + i);
            found = 1'b1;
         end
      end
   end

   // IDLE drops the granted request and any request that would not change the cluster
   assign gmask     = found ? NumClusters'(1) << grant : '0;
   assign clr_start = state == IDLE ? (on_o | gmask) : '0;
   assign clr_stop  = state == IDLE ? (~on_o | gmask) : '0;

   // request latching plus the sequencing FSM driving the per-cluster outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         ptr        <= '0;
         cur        <= '0;
         cnt        <= '0;
         pend_start <= '0;
         pend_stop  <= '0;
         clk_en_o   <= '0;
         rst_o      <= '1;
         boot_irq_o <= '0;
         on_o       <= '0;
      end else begin
         pend_start <= ((pend_start & ~clr_start) | start_i) & ~stop_i;
         pend_stop  <= (pend_stop & ~clr_stop & ~start_i) | stop_i;
         case (state)
            IDLE: if (found) begin
               cur          <= grant;
               ptr          <= wrap(int'(grant) + 1);
               rst_o[grant] <= 1'b1;
               if (pend_start[grant] && !on_o[grant]) begin
                  clk_en_o[grant] <= 1'b1;
                  cnt             <= CW'(ClkSettleCycles);
                  state           <= UP_CLK;
               end else begin
                  on_o[grant] <= 1'b0;
                  cnt         <= CW'(RstHoldCycles);
                  state       <= DN_RST;
               end
            end
            UP_CLK: if (cnt == CW'(1)) begin
               cnt   <= CW'(RstHoldCycles);
               state <= UP_RST;
            end else cnt <= cnt - CW'(1);
            UP_RST: if (cnt == CW'(1)) begin
               rst_o[cur]      <= 1'b0;
               boot_irq_o[cur] <= 1'b1;
               state           <= UP_IRQ;
            end else cnt <= cnt - CW'(1);
            UP_IRQ: begin
               boot_irq_o[cur] <= 1'b0;
               on_o[cur]       <= 1'b1;
               state           <= IDLE;
            end
            DN_RST: if (cnt == CW'(1)) begin
               clk_en_o[cur] <= 1'b0;
               state         <= DN_CLK;
            end else cnt <= cnt - CW'(1);
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/chimera_cluster_seq.md
# chimera_cluster_seq

Shared power-up/power-down sequencer for the external compute clusters. It takes start/stop requests from the top-level configuration registers and serves them one cluster at a time, with round-robin arbitration. For each served cluster it drives clock enable, cluster reset and a boot interrupt in a fixed order, which bounds inrush current on the shared supply and the clock tree. It sits between the top-level register file and the per-cluster clock gates and reset inputs.

## Interface
Parameters:
- NumClusters, 5: number of external clusters served.
- ClkSettleCycles, 8: cycles the clock runs with reset held before the reset hold phase starts (≥1).
- RstHoldCycles, 16: cycles of reset assertion with the clock running (≥1).

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  NumClusters  one-cycle start request per cluster.
- stop_i  in  NumClusters  one-cycle stop request per cluster.
- clk_en_o  out  NumClusters  clock-gate enable per cluster (registered).
- rst_o  out  NumClusters  active-high cluster reset (registered).
- boot_irq_o  out  NumClusters  one-cycle boot pulse per cluster.
- on_o  out  NumClusters  cluster is fully up.
- busy_o  out  1  sequencer is not in IDLE.
- cluster_idle_i  in  NumClusters  cluster reports WFI/idle; present only with the macro below.

## Operation
- Reset values:
  - clk_en_o = 0, rst_o = all ones, boot_irq_o = 0, on_o = 0, busy_o = 0.
  - Pending start and pending stop bits = 0; round-robin pointer = 0; state = IDLE.
- Request latching, per cluster:
  - start_i sets pend_start and clears pend_stop.
  - stop_i sets pend_stop and clears pend_start.
  - start_i and stop_i in the same cycle: stop wins.
  - Requests for the cluster currently being sequenced are latched and evaluated after the current sequence completes.
- Eligibility:
  - pend_start with on = 0, or pend_stop with on = 1.
  - A redundant pending bit (start while on, stop while off) is cleared in IDLE without sequencing.
- Arbitration in IDLE:
  - Grant the first eligible cluster at or after the round-robin pointer, wrapping modulo NumClusters.
  - Clear that cluster's pending bit.
  - Set the pointer to grant+1, wrapping from NumClusters-1 to 0.
- FSM states: IDLE, UP_CLK, UP_RST, UP_IRQ, DN_RST, DN_CLK.
  - IDLE → UP_CLK on a start grant: clk_en_o[g] = 1, rst_o[g] = 1.
  - IDLE → DN_RST on a stop grant: on_o[g] = 0, rst_o[g] = 1.
  - UP_CLK, ClkSettleCycles cycles → UP_RST.
  - UP_RST, RstHoldCycles cycles → UP_IRQ: rst_o[g] = 0, boot_irq_o[g] = 1.
  - UP_IRQ, 1 cycle → IDLE: boot_irq_o[g] = 0, on_o[g] = 1.
  - DN_RST, RstHoldCycles cycles → DN_CLK: clk_en_o[g] = 0.
  - DN_CLK, 1 cycle → IDLE.
- Dwell counter:
  - Single down-counter, width $clog2(max(ClkSettleCycles, RstHoldCycles)+1).
  - Loaded on state entry; the transition is taken when the counter reads 1.
  - Never wraps.
- Non-granted clusters' outputs hold their values.

## Timing
- A start_i pulse in cycle T is latched at the end of T. IDLE grants in T+1.
- clk_en_o[g] rises in T+2.
- rst_o[g] falls and boot_irq_o[g] pulses in T+2+ClkSettleCycles+RstHoldCycles.
- on_o[g] rises one cycle after the boot pulse.
- Stop, with stop_i at T:
  - rst_o[g] rises and on_o[g] falls in T+2.
  - clk_en_o[g] falls in T+2+RstHoldCycles.
  - busy_o falls one cycle later.
- busy_o = 1 in every non-IDLE state. IDLE lasts at least one cycle between sequences.
- rst_i asserted mid-sequence: all registers take reset values at the next edge and the sequence is aborted. Clusters are left gated and in reset, and pending requests are lost.

## Configuration
- CHIMERA_CLUSTER_SEQ_WFI_GATE_EN:
  - Defined: the cluster_idle_i port exists. A stop request is eligible only while cluster_idle_i[g] = 1; otherwise it stays pending and arbitration skips that cluster.
  - Undefined: the port is absent and stops are granted unconditionally.

## Test plan
- Single start: start_i = 5'b00100 at T → clk_en_o[2] rises at T+2, rst_o[2] falls and boot_irq_o[2] pulses at T+26, on_o[2] rises at T+27, busy_o falls at T+27.
- Round-robin: start_i = 5'b11111 in one cycle → clusters power up in order 0,1,2,3,4, with no overlap of busy phases; then start_i = 5'b00011 with pointer = 0 → cluster 0 before cluster 1.
- Redundant/conflicting requests:
  - start_i[1] while on_o[1] = 1 → no output change.
  - start_i[3] and stop_i[3] in the same cycle while off → nothing happens.
- Stop: stop_i[0] at T with cluster 0 on → rst_o[0] rises at T+2, clk_en_o[0] falls at T+18.
- Reset mid-sequence: rst_i asserted during UP_RST of cluster 2 → the next cycle shows clk_en_o = 0, rst_o = 5'b11111, busy_o = 0, and no boot pulse afterwards.
- WFI gate (macro defined): stop_i[4] with cluster_idle_i[4] = 0 for 50 cycles → no action and busy_o stays 0; when cluster_idle_i[4] rises → rst_o[4] rises 2 cycles later.
